wu_memory: RTL and testbench

WU_MEMORY -- requirements
Module: wu_memory

---
 rtl/wu_memory.sv | 110 +++++++++++
 tb/tb_wu_memory.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/wu_memory.sv
// WU instruction memory: preloadable synchronous array feeding a credit-managed output FIFO.
// Each read spends one cycle in flight, then queues {addr, data} for the decoder in request order.
module wu_memory #(
    parameter int WU_ADDR_WIDTH = 10,
    parameter int WU_DATA_WIDTH = 32,
    parameter int OBUF_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset_poweron,
    input  logic                     wuf__wum__read,
    input  logic [WU_ADDR_WIDTH-1:0] wuf__wum__addr,
    output logic                     wum__wuf__stall,
    input  logic                     sys__wum__write,
    input  logic [WU_ADDR_WIDTH-1:0] sys__wum__addr,
    input  logic [WU_DATA_WIDTH-1:0] sys__wum__wdata,
    output logic                     wum__wud__valid,
    output logic [WU_DATA_WIDTH-1:0] wum__wud__data,
    output logic [WU_ADDR_WIDTH-1:0] wum__wud__addr,
    input  logic                     wud__wum__ready,
    output logic                     wum__sys__overflow
);

    localparam int PTR_W     = $clog2(OBUF_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int CRD_W     = CNT_W + 2;
    localparam int MEM_DEPTH = 1 << WU_ADDR_WIDTH;

    logic [WU_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                     vld_p1;
    logic [WU_DATA_WIDTH-1:0] rd_data_p1;
    logic [WU_ADDR_WIDTH-1:0] rd_addr_p1;

    logic [WU_DATA_WIDTH-1:0] obuf_data [OBUF_DEPTH];
    logic [WU_ADDR_WIDTH-1:0] obuf_addr [OBUF_DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         count;

    logic                     stall_q;
    logic                     overflow_q;
    logic                     pop;
    logic                     accept;
    logic                     drop;
    logic signed [CRD_W-1:0]  credit;

    // A word leaving the FIFO this cycle has already freed its slot.
    function automatic logic signed [CRD_W-1:0] calc_credit(
        input logic [CNT_W-1:0] occ,
        input logic             leaving,
        input logic             in_flight
    );
        calc_credit = $signed(CRD_W'(OBUF_DEPTH))
                    - $signed({2'b00, occ})
                    + $signed(CRD_W'(leaving))
                    - $signed(CRD_W'(in_flight));
    endfunction

    assign wum__wud__valid    = (count != '0);
    assign pop                = wum__wud__valid && wud__wum__ready;
    assign credit             = calc_credit(count, pop, vld_p1);
    assign accept             = wuf__wum__read && (credit > 0);
    assign drop               = wuf__wum__read && !accept;
    assign wum__wud__data     = wum__wud__valid ? obuf_data[rd_ptr] : '0;
    assign wum__wud__addr     = wum__wud__valid ? obuf_addr[rd_ptr] : '0;
    assign wum__wuf__stall    = stall_q;
    assign wum__sys__overflow = overflow_q;

    // Stage p0 -> p1: array access (read-before-write on address collision)
    always_ff @(posedge clk) begin
        if (sys__wum__write) begin
            mem[sys__wum__addr] <= sys__wum__wdata;
        end
        if (accept) begin
            rd_data_p1 <= mem[wuf__wum__addr];
            rd_addr_p1 <= wuf__wum__addr;
        end
        // Stage p1 -> FIFO: in-flight word lands in the output buffer
        if (vld_p1) begin
            obuf_data[wr_ptr] <= rd_data_p1;
            obuf_addr[wr_ptr] <= rd_addr_p1;
        end
    end

    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            vld_p1     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            vld_p1 <= accept;
            if (vld_p1) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count   <= count + CNT_W'(vld_p1) - CNT_W'(pop);
            // Two slots of margin cover the reads fetch issues before it sees stall.
            stall_q <= (credit <= 2);
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wu_memory.sv
// Scoreboard bench for wu_memory: directed reads push expected {addr, data};
// a negedge monitor pops and compares every word the decoder accepts.
module tb_wu_memory;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_poweron;
    logic          rd;
    logic [AW-1:0] raddr;
    logic          stall;
    logic          wr;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          valid;
    logic [DW-1:0] data;
    logic [AW-1:0] oaddr;
    logic          ready;
    logic          overflow;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    wu_memory #(.WU_ADDR_WIDTH(AW), .WU_DATA_WIDTH(DW), .OBUF_DEPTH(4)) dut (
        .clk                (clk),
        .reset_poweron      (reset_poweron),
        .wuf__wum__read     (rd),
        .wuf__wum__addr     (raddr),
        .wum__wuf__stall    (stall),
        .sys__wum__write    (wr),
        .sys__wum__addr     (waddr),
        .sys__wum__wdata    (wdata),
        .wum__wud__valid    (valid),
        .wum__wud__data     (data),
        .wum__wud__addr     (oaddr),
        .wud__wum__ready    (ready),
        .wum__sys__overflow (overflow)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d words outstanding, expected 0", name, exp_q.size());
        end
    endtask

    // Monitor: every accepted output word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset_poweron && valid && ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got addr 0x%0h data 0x%0h, expected none", oaddr, data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_addr", oaddr, e.addr);
                check("out_data", data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_poweron = 1'b1;
        rd = 1'b0; raddr = '0;
        wr = 1'b0; waddr = '0; wdata = '0;
        ready = 1'b0;
        tick();

        // Preload 0..7 with 0x100+addr while held in reset
        for (int i = 0; i < 8; i++) begin
            wr = 1'b1; waddr = AW'(i); wdata = DW'(32'h100 + i);
            tick();
        end
        wr = 1'b0;
        @(negedge clk);
        check("rst_valid", valid, 0);
        check("rst_stall", stall, 0);
        check("rst_overflow", overflow, 0);
        check("rst_data", data, 0);
        check("rst_addr", oaddr, 0);
        tick();

        // Streaming reads with ready held high, starting right after release
        reset_poweron = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rd = 1'b1; raddr = AW'(i);
            exp_q.push_back('{addr: AW'(i), data: DW'(32'h100 + i)});
            tick();
            check("stream_stall", stall, 0);
            if (i == 0) check("latency_cycle1_valid", valid, 0);
            if (i == 1) check("latency_cycle2_valid", valid, 1);
        end
        rd = 1'b0;
        drain("stream");
        check("stream_stall_end", stall, 0);

        // Same-cycle write and read of address 5 returns the old word
        wr = 1'b1; waddr = AW'(5); wdata = DW'(32'hABCD);
        rd = 1'b1; raddr = AW'(5);
        exp_q.push_back('{addr: AW'(5), data: DW'(32'h105)});
        tick();
        wr = 1'b0; rd = 1'b0;
        tick();
        rd = 1'b1; raddr = AW'(5);
        exp_q.push_back('{addr: AW'(5), data: DW'(32'hABCD)});
        tick();
        rd = 1'b0;
        drain("rw_collision");

        // Fill with ready low: stall appears once credit has fallen to 2
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd = 1'b1; raddr = AW'(i);
            exp_q.push_back('{addr: AW'(i), data: DW'(32'h100 + i)});
            tick();
            check("fill_stall", stall, logic'(i >= 2));
        end
        rd = 1'b0;
        tick();
        check("full_overflow", overflow, 0);
        check("full_valid", valid, 1);
        check("full_head_addr", oaddr, 0);
        check("full_stall", stall, 1);

        // Fifth read into a full buffer is dropped
        rd = 1'b1; raddr = AW'(4);
        tick();
        rd = 1'b0;
        check("drop_overflow", overflow, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("drop_overflow_sticky", overflow, 1);
            check("drop_head_addr", oaddr, 0);
            check("drop_head_data", data, 32'h100);
        end

        // Full buffer: pop and read together, order preserved
        ready = 1'b1;
        rd = 1'b1; raddr = AW'(6);
        exp_q.push_back('{addr: AW'(6), data: DW'(32'h106)});
        tick();
        rd = 1'b0;
        check("pushpop_valid", valid, 1);
        drain("push_pop");
        tick();
        check("pushpop_overflow_kept", overflow, 1);
        check("pushpop_stall_released", stall, 0);

        // Three words buffered (not expected out), then asynchronous reset
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd = 1'b1; raddr = AW'(i);
            tick();
        end
        rd = 1'b0;
        tick();
        check("pre_reset_stall", stall, 1);
        reset_poweron = 1'b1;
        #1;
        check("async_rst_valid", valid, 0);
        check("async_rst_stall", stall, 0);
        check("async_rst_overflow", overflow, 0);
        check("async_rst_data", data, 0);
        check("async_rst_addr", oaddr, 0);
        tick();
        reset_poweron = 1'b0;
        ready = 1'b1;
        rd = 1'b1; raddr = AW'(7);
        exp_q.push_back('{addr: AW'(7), data: DW'(32'h107)});
        tick();
        rd = 1'b0;
        drain("after_reset");
        check("after_reset_overflow", overflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
